decoder_3to8: RTL and testbench
===============================

DECODER_3TO8 -- requirements
Module: decoder_3to8

Interface
REQ-001 Parameter: SEL_W, default 3, select width; fixed at 3 for this block.
REQ-002 Parameter: OUT_W, default 8, output width; SHALL equal 2**SEL_W.
REQ-003 Port: clk  input  1  single clock; all sequential logic on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in  input  3  binary select code.
REQ-006 Port: en  input  1  decode enable, active-high.
REQ-007 Port: out  output  8  combinational one-hot decode of in.
REQ-008 Port: out_q  output  8  registered copy of out.
REQ-009 Port: valid_q  output  1  registered en; high when out_q holds a decoded value.

Function
REQ-010 out SHALL be purely combinational from in and en, with zero clock latency, independent of clk and rst.
REQ-011 With en=1, out SHALL equal 8'b0000_0001 shifted left by in: exactly bit[in] high, all other bits low.
REQ-012 With en=0, out SHALL be 8'b0000_0000 for every value of in.
REQ-013 out SHALL settle within one simulation delta of any change on in or en; no glitch-holding state or latches.
REQ-014 If in or en is X or Z, out SHALL be 8'b0000_0000; a one-hot output must never be asserted from unknown inputs.
REQ-015 On each rising clk with rst=0: out_q <= out and valid_q <= en; latency is exactly 1 cycle.
REQ-016 out_q SHALL always be one-hot or all-zero; it is never multi-hot.
REQ-017 There are no wrap-around or overflow cases; all 8 codes of in are legal.

Reset
REQ-018 On a rising clk with rst=1: out_q <= 8'b0000_0000 and valid_q <= 0.
REQ-019 rst SHALL have priority over en and in on the same edge.
REQ-020 rst SHALL NOT affect the combinational out.
REQ-021 Deasserting rst SHALL take effect at the next rising edge; the first post-reset edge captures the current out.
REQ-022 Before the first clock edge, out_q and valid_q are undefined.

Structure
REQ-023 A shared package decoder_pkg SHALL hold SEL_W=3, OUT_W=8 and a function returning the one-hot vector for a select code.
REQ-024 One sub-module, onehot_decode_core, SHALL hold the pure combinational decode; the top adds the en gating and the output register.
REQ-025 Target implementation size is 120-400 lines of RTL, including package, core, top and assertions.
REQ-026 Synthesizable; no latches; no initial blocks in RTL.

Verification
REQ-027 Scenario: en=0, in=3'b000, wait 5 ns -> out=8'b0000_0000.
REQ-028 Scenario: en=1, in swept 0..7 at 5 ns steps -> out=1<<in each step (e.g., in=5 -> 8'b0010_0000); no other bit set.
REQ-029 Scenario: en=1, in=3'b111, then en=0 -> out goes 8'b1000_0000 to 8'b0000_0000 with no clock edge required.
REQ-030 Scenario: rst=1 for 2 cycles with en=1, in=3 -> out_q=8'b0, valid_q=0; rst=0 -> after next edge out_q=8'b0000_1000, valid_q=1.
REQ-031 Scenario: random in/en for 200 cycles -> out_q equals the previous cycle's out; a one-hot-or-zero assertion on out and out_q never fires.
REQ-032 Scenario: in=3'bx1x with en=1 -> out=8'b0000_0000.

Source files
------------

// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared widths and the one-hot select helper for decoder_3to8.
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned OUT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [OUT_W-1:0] onehot_t;

    // Equality compare per bit: an unknown select never matches, so the result is all-zero.
    function automatic onehot_t onehot_of(input sel_t sel);
        onehot_t res;
        res = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            if (sel == SEL_W'(i)) begin
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/onehot_decode_core.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decode_core
// Description : Pure combinational binary-to-one-hot decode, no gating.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_decode_core
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W = decoder_pkg::SEL_W,
    parameter int unsigned OUT_W = decoder_pkg::OUT_W
) (
    input  logic [SEL_W-1:0] i_sel,
    output logic [OUT_W-1:0] o_onehot
);

    always_comb begin
        o_onehot = onehot_of(i_sel);
    end

endmodule : onehot_decode_core
`default_nettype wire

// File: rtl/decoder_3to8.sv
`default_nettype none
// ============================================================================
// Module      : decoder_3to8
// Description : Enable-gated 3-to-8 one-hot decoder with a registered copy.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_3to8
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W = decoder_pkg::SEL_W,
    parameter int unsigned OUT_W = decoder_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] in,
    input  logic             en,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_q,
    output logic             valid_q
);

    logic [OUT_W-1:0] w_onehot;
    logic [OUT_W-1:0] w_out;
    logic [OUT_W-1:0] r_out_q;
    logic             r_valid_q;

    onehot_decode_core #(
        .SEL_W (SEL_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_sel    (in),
        .o_onehot (w_onehot)
    );

    // An if (rather than ?:) makes an unknown enable fall through to all-zero.
    always_comb begin
        w_out = '0;
        if (en == 1'b1) begin
            w_out = w_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_out_q   <= w_out;
            r_valid_q <= en;
        end
    end

    assign out     = w_out;
    assign out_q   = r_out_q;
    assign valid_q = r_valid_q;

    a_out_onehot0 : assert property (@(posedge clk) $onehot0(out));
    a_out_q_onehot0 : assert property (@(posedge clk) !$isunknown(out_q) |-> $onehot0(out_q));

endmodule : decoder_3to8
`default_nettype wire

// File: tb/tb_decoder_3to8.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_3to8
// Description : Randomized self-checking bench for decoder_3to8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_3to8;

    logic       clk;
    logic       rst;
    logic [2:0] in;
    logic       en;
    logic [7:0] out;
    logic [7:0] out_q;
    logic       valid_q;

    int n_total;
    int n_bad;

    logic [7:0] exp_q;
    logic       exp_v;

    decoder_3to8 u_dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .en      (en),
        .out     (out),
        .out_q   (out_q),
        .valid_q (valid_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: a lit bit only for a clean enable and a fully known code.
    function automatic logic [7:0] model(input logic [2:0] s, input logic e);
        if (e !== 1'b1 || $isunknown(s)) return 8'h00;
        return 8'(2 ** int'(s));
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        en  = 1'b0;
        in  = 3'd0;

        #4;
        check("idle_disabled", out, 8'h00);

        en = 1'b1;
        in = 3'd3;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_out_q", out_q, 8'h00);
            check("rst_valid_q", {7'd0, valid_q}, 8'h00);
            check("rst_comb_out", out, 8'b0000_1000);
        end

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_out_q", out_q, 8'b0000_1000);
        check("post_rst_valid_q", {7'd0, valid_q}, 8'h01);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in = 3'(i);
            #1;
            check("sweep", out, model(in, 1'b1));
        end

        @(negedge clk);
        in = 3'b111;
        en = 1'b1;
        #1;
        check("msb_on", out, 8'b1000_0000);
        en = 1'b0;
        #1;
        check("msb_off_no_clk", out, 8'h00);

        @(negedge clk);
        in = 3'bx1x;
        en = 1'b1;
        #1;
        check("unknown_sel", out, model(in, en));
        in = 3'd5;
        en = 1'bx;
        #1;
        check("unknown_en", out, model(in, en));
        en = 1'b0;
        in = 3'd0;

        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 19) == 0);
            in  = 3'($urandom);
            en  = 1'($urandom);
            #1;
            check("rand_comb", out, model(in, en));
            exp_q = rst ? 8'h00 : model(in, en);
            exp_v = rst ? 1'b0 : en;
            @(posedge clk);
            #1;
            check("rand_out_q", out_q, exp_q);
            check("rand_valid_q", {7'd0, valid_q}, {7'd0, exp_v});
        end

        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        in  = 3'd6;
        @(posedge clk);
        #1;
        check("rst_priority_out_q", out_q, 8'h00);
        check("rst_priority_valid_q", {7'd0, valid_q}, 8'h00);
        check("rst_priority_comb", out, 8'b0100_0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_decoder_3to8
`default_nettype wire
